// File: rtl/bdd_vector_loader.sv
// rtl/bdd_vector_loader.sv - assembles the wide bank input vector from a word stream,
// waits a fixed settle time, then returns the bank's output bits on a valid/ready port.
module bdd_vector_loader #(
  parameter int IN_W   = 1894,
  parameter int WORD_W = 32,
  parameter int OUT_W  = 128,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic [IN_W-1:0]   vec_o,
  input  logic [OUT_W-1:0]  res_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [OUT_W-1:0]  m_data,
  output logic              err,
  output logic              busy
);

  localparam int NUM_WORDS = (IN_W + WORD_W - 1) / WORD_W;
  localparam int WCNT_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCNT_W-1:0] LAST_IDX    = WCNT_W'(NUM_WORDS - 1);
  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [3:0]         r_scnt;
  logic [IN_W-1:0]    r_vec;
  logic [IN_W-1:0]    w_vec_next;
  logic [OUT_W-1:0]   r_m_data;
  logic               r_err;

  logic w_xfer;
  logic w_wr;
  logic w_at_last;
  logic w_good;
  logic w_short;
  logic w_long;
  logic w_capture;

  assign w_xfer    = s_valid & s_ready;
  assign w_wr      = w_xfer & (r_state == ST_LOAD);
  assign w_at_last = (r_wcnt == LAST_IDX);
  assign w_good    = w_wr & s_last & w_at_last;
  assign w_short   = w_wr & s_last & ~w_at_last;
  assign w_long    = w_wr & ~s_last & w_at_last;
  assign w_capture = (r_state == ST_SETTLE) && (r_scnt == 4'd0);

  // Each word owns a fixed slice; the final slice is narrower, so its upper data bits are dropped.
  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_slice
    localparam int LO = g * WORD_W;
    localparam int W  = ((IN_W - LO) < WORD_W) ? (IN_W - LO) : WORD_W;
    assign w_vec_next[LO +: W] = (w_wr && (r_wcnt == WCNT_W'(g))) ? s_data[W-1:0]
                                                                  : r_vec[LO +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_LOAD: begin
        if (w_good) begin
          w_state_next = ST_SETTLE;
        end else if (w_long) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_xfer && s_last) begin
          w_state_next = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (r_scnt == 4'd0) begin
          w_state_next = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          w_state_next = ST_LOAD;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b1;
    m_valid = 1'b0;
    unique case (r_state)
      ST_LOAD: begin
        s_ready = ~rst;
        busy    = 1'b0;
      end
      ST_DRAIN:  s_ready = ~rst;
      ST_SETTLE: s_ready = 1'b0;
      ST_OUT:    m_valid = 1'b1;
      default: begin
        s_ready = 1'b0;
        busy    = 1'b1;
        m_valid = 1'b0;
      end
    endcase
  end

  // Every frame end, good or bad, restarts the word index so the next frame begins at slice 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
      r_scnt <= 4'd0;
      r_vec  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_vec <= w_vec_next;
      r_err <= w_short | w_long;
      if (w_wr) begin
        if (s_last || w_at_last) begin
          r_wcnt <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
      if (w_good) begin
        r_scnt <= SETTLE_INIT;
      end else if ((r_state == ST_SETTLE) && (r_scnt != 4'd0)) begin
        r_scnt <= r_scnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data <= '0;
    end else if (w_capture) begin
      r_m_data <= res_i;
    end
  end

  assign vec_o  = r_vec;
  assign m_data = r_m_data;
  assign err    = r_err;

endmodule

// File: tb/tb_bdd_vector_loader.sv
// tb/tb_bdd_vector_loader.sv - scoreboard bench for the vector loader with a
// behavioural bank model driving res_i.
module tb_bdd_vector_loader;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [1893:0] vec_o;
  logic [127:0]  res_i;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [127:0]  m_data;
  logic          err;
  logic          busy;

  int            tests = 0;
  int            fails = 0;
  logic [127:0]  exp_q[$];
  logic [1919:0] mvec = '0;

  always #5 clk = ~clk;

  function automatic logic [127:0] bank(input logic [1893:0] v);
    logic [127:0] r;
    for (int j = 0; j < 128; j++) begin
      r[j] = v[j] ^ v[1893 - j] ^ (^v[j*14 +: 14]) ^ v[(j * 7 + 1000) % 1894];
    end
    return r;
  endfunction

  assign res_i = bank(vec_o);

  bdd_vector_loader dut (
    .clk    (clk),
    .rst    (rst),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .vec_o  (vec_o),
    .res_i  (res_i),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .err    (err),
    .busy   (busy)
  );

  task automatic xfer(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_data  = d;
    s_last  = l;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL xfer_timeout: s_ready=%0b required 1", s_ready);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input bit use_k, input bit gaps);
    logic [31:0] d;
    for (int k = 0; k < 60; k++) begin
      d = use_k ? 32'(k) : 32'($urandom);
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
      mvec[k*32 +: 32] = d;
      xfer(d, k == 59);
    end
    exp_q.push_back(bank(mvec[1893:0]));
  endtask

  task automatic get_result();
    int n;
    logic [127:0] e;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (!m_valid) begin
      fails++;
      $display("FAIL result_timeout: m_valid=%0b required 1", m_valid);
    end else if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL result_unexpected: m_data=%h with empty scoreboard", m_data);
    end else begin
      e = exp_q.pop_front();
      if (m_data !== e) begin
        fails++;
        $display("FAIL result_data: got %h required %h", m_data, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({s_ready, m_valid, err, busy} !== 4'b0000 || vec_o !== '0 || m_data !== '0) begin
      fails++;
      $display("FAIL reset_state: rdy/val/err/busy=%b vec_nz=%0b mdata=%h required 0000/0/0",
               {s_ready, m_valid, err, busy}, |vec_o, m_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready: s_ready=%b required 1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [127:0] e;
    m_ready = 1'b1;
    send_frame(1'b1, 1'b0);
    @(negedge clk);
    tests++;
    if ({m_valid, busy, s_ready} !== 3'b010) begin
      fails++;
      $display("FAIL basic_settle1: val/busy/rdy=%b required 010", {m_valid, busy, s_ready});
    end
    @(negedge clk);
    tests++;
    if (m_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_settle2: m_valid=%b required 0", m_valid);
    end
    @(negedge clk);
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL basic_latency: m_valid=%b required 1", m_valid);
    end
    e = exp_q.pop_front();
    tests++;
    if (m_data !== e) begin
      fails++;
      $display("FAIL basic_data: got %h required %h", m_data, e);
    end
    tests++;
    if (vec_o[31:0] !== 32'd0 || vec_o[63:32] !== 32'd1 || vec_o[1893:1888] !== 6'd59) begin
      fails++;
      $display("FAIL basic_vec: w0=%h w1=%h top=%h required 0/1/3b",
               vec_o[31:0], vec_o[63:32], vec_o[1893:1888]);
    end
    @(negedge clk);
    tests++;
    if ({m_valid, s_ready} !== 2'b01) begin
      fails++;
      $display("FAIL basic_one_cycle: val/rdy=%b required 01", {m_valid, s_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    logic [127:0] hold;
    logic [127:0] e;
    int n;
    m_ready = 1'b0;
    send_frame(1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    hold = m_data;
    e = exp_q.pop_front();
    tests++;
    if (m_valid !== 1'b1 || m_data !== e) begin
      fails++;
      $display("FAIL bp_data: val=%b got %h required 1 %h", m_valid, m_data, e);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (m_valid !== 1'b1 || m_data !== hold || s_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold: val=%b rdy=%b data=%h required 1 0 %h", m_valid, s_ready, m_data, hold);
      end
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if ({m_valid, s_ready} !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: val/rdy=%b required 01", {m_valid, s_ready});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_short_frame();
    logic seen;
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mvec[k*32 +: 32] = 32'(100 + k);
      xfer(32'(100 + k), k == 4);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL short_err: err=%b required 1", err);
    end
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || vec_o !== mvec[1893:0]) begin
      fails++;
      $display("FAIL short_err_pulse_vec: err=%b vec_match=%b required 0 1", err, vec_o === mvec[1893:0]);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen = seen | m_valid;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL short_no_result: m_valid seen=%b required 0", seen);
    end
    @(posedge clk);
    #1;
    send_frame(1'b0, 1'b0);
    get_result();
  endtask

  task automatic test_long_frame();
    logic [31:0] d;
    logic seen;
    m_ready = 1'b1;
    for (int k = 0; k < 62; k++) begin
      d = 32'($urandom);
      if (k < 60) mvec[k*32 +: 32] = d;
      xfer(d, k == 61);
      if (k == 59) begin
        @(negedge clk);
        tests++;
        if (err !== 1'b1 || busy !== 1'b1) begin
          fails++;
          $display("FAIL long_err: err=%b busy=%b required 1 1", err, busy);
        end
      end
    end
    @(negedge clk);
    tests++;
    if (vec_o !== mvec[1893:0] || busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL long_drain: vec_match=%b busy=%b err=%b required 1 0 0",
               vec_o === mvec[1893:0], busy, err);
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen = seen | m_valid;
    end
    tests++;
    if (seen !== 1'b0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL long_no_result: m_valid seen=%b pending=%0d required 0 0", seen, exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          send_frame(1'b0, 1'b1);
        end
      end
      begin
        int got;
        int cyc;
        logic [127:0] e;
        got = 0;
        cyc = 0;
        while (got < 200 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (m_valid && m_ready) begin
            tests++;
            got++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL rand_extra: result %0d with empty scoreboard", got);
            end else begin
              e = exp_q.pop_front();
              if (m_data !== e) begin
                fails++;
                $display("FAIL rand_data: frame %0d got %h required %h", got, m_data, e);
              end
            end
          end
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
        tests++;
        if (got != 200) begin
          fails++;
          $display("FAIL rand_count: got %0d results required 200", got);
        end
      end
    join
    m_ready = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL rand_leftover: %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int n;
    m_ready = 1'b1;
    for (int k = 0; k < 31; k++) begin
      xfer(32'($urandom), 1'b0);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (vec_o !== '0 || {m_valid, busy, s_ready} !== 3'b000) begin
      fails++;
      $display("FAIL rst_mid: vec_nz=%b val/busy/rdy=%b required 0 000", |vec_o, {m_valid, busy, s_ready});
    end
    mvec = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_frame(1'b0, 1'b0);
    get_result();

    m_ready = 1'b0;
    send_frame(1'b0, 1'b0);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (m_valid !== 1'b1) begin
      fails++;
      $display("FAIL rst_out_setup: m_valid=%b required 1", m_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (vec_o !== '0 || {m_valid, busy} !== 2'b00 || m_data !== '0) begin
      fails++;
      $display("FAIL rst_out: vec_nz=%b val/busy=%b mdata=%h required 0 00 0",
               |vec_o, {m_valid, busy}, m_data);
    end
    exp_q.delete();
    mvec = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    send_frame(1'b1, 1'b0);
    get_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bdd_vector_loader.md
Name: bdd_vector_loader

Overview:
- Front-end driver for a bank of learned combinational output-bit modules, the writer side of the wide input bus those modules read.
- Assembles the 1894-bit CPU state vector from a narrow valid/ready word stream.
- Holds the vector stable for the bank, waits a fixed settle time, then captures the bank's output bits and returns them on a valid/ready result port.
- Sits between the trace/stimulus DMA and the cluster of output-bit modules.

Parameters:
IN_W, 1894, width of the assembled state vector driven to the bank
WORD_W, 32, input word width
OUT_W, 128, number of output bits returned by the bank
SETTLE, 2, cycles from the last word accepted to result capture (legal range 1..15)
Derived: NUM_WORDS = ceil(IN_W/WORD_W) = 60; the last word uses its low IN_W-(NUM_WORDS-1)*WORD_W = 6 bits.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  input word valid
s_ready  out  1  loader can accept a word
s_data  in  WORD_W  input word; word k maps to vec_o bits [k*WORD_W +: WORD_W], truncated at IN_W
s_last  in  1  marks the final word of a frame
vec_o  out  IN_W  assembled vector, driven to every bank module's i
res_i  in  OUT_W  combinational outputs of the bank modules
m_valid  out  1  result valid
m_ready  in  1  downstream accepts the result
m_data  out  OUT_W  captured result bits
err  out  1  one-cycle pulse on a framing error
busy  out  1  high in every state other than LOAD

Behaviour:
- Reset (async assert, sync release): state=LOAD, word count wcnt=0, settle count=0, vec_o=0, m_valid=0, m_data=0, err=0. s_ready=0 while rst is high.
- Handshake: a word transfers on s_valid&s_ready at a rising edge. A result transfers on m_valid&m_ready.
- LOAD (s_ready=1):
  - On each transfer, write the word into vec_o slice wcnt. Bits beyond IN_W are dropped. Other slices keep their values.
  - Transfer with wcnt<NUM_WORDS-1 and s_last=0: wcnt+1.
  - Transfer with wcnt==NUM_WORDS-1 and s_last=1: wcnt=0, go to SETTLE, settle count=SETTLE-1.
  - Transfer with s_last=1 and wcnt!=NUM_WORDS-1 (short frame): err=1 for one cycle, wcnt=0, stay in LOAD. The partially written vector stays in vec_o and no result is produced.
  - Transfer with wcnt==NUM_WORDS-1 and s_last=0 (long frame): err=1 for one cycle, wcnt=0, go to DRAIN.
- DRAIN (s_ready=1): discard words and leave vec_o unchanged. A transfer with s_last=1 returns to LOAD.
- SETTLE (s_ready=0): vec_o is held constant. Decrement the settle count each cycle. At 0, capture res_i into m_data, set m_valid=1, go to OUT.
- OUT (s_ready=0): m_valid and m_data are held until m_ready. On the handshake, m_valid=0 and state returns to LOAD. A new frame can start on the next cycle.
- m_data changes only at capture. If m_ready is already high on the capture cycle, the result is held for exactly 1 cycle.
- Latency: last word accepted at edge t, m_valid high after edge t+SETTLE.
- vec_o changes only on accepted LOAD words, so the bank inputs are stable for the whole SETTLE/OUT period.
- Async reset in any state aborts immediately. A partial frame, a pending result and a DRAIN in progress are all discarded.

Test Plan:
- Reset then 60 words with value k for word k, s_last on word 59 -> vec_o[31:0]=0, vec_o[63:32]=1, vec_o[1893:1888]=6'd59. m_valid rises 2 cycles after the last transfer. m_data equals the res_i sampled at capture.
- Same frame with m_ready=0 for 10 cycles -> m_valid and m_data stable and s_ready=0 throughout. After m_ready, s_ready=1 on the next cycle.
- Short frame of 5 words with s_last on word 4 -> err pulses 1 cycle, no m_valid. A following good 60-word frame produces a normal result.
- Long frame of 62 words with s_last on word 61 -> err pulses on the transfer of word 59, words 60-61 are discarded with vec_o unchanged, no result.
- Random s_valid gaps (50%) and random m_ready over 200 frames -> each m_data matches a reference model of bank(vec_o). Exactly one result per good frame.
- rst asserted mid-frame (word 30) and again in OUT -> vec_o=0, m_valid=0 and state LOAD in the same cycle. The next frame loads from word 0.
